lcd_frame_sink: RTL and testbench



---
 rtl/lcd_frame_sink_if.sv | 28 ++
 rtl/lcd_frame_sink.sv | 194 +++++++++++++++++++
 tb/tb_lcd_frame_sink.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/lcd_frame_sink_if.sv
// FIFO-side and pixel-side signal bundle for lcd_frame_sink.
// The slave modport is the sink itself; the master modport is its environment.
interface lcd_frame_sink_if;
    logic [16:0] queue_data;
    logic        queue_empty;
    logic        queue_rd_en;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic [15:0] pix_x;
    logic [15:0] pix_y;
    logic        pix_sof;
    logic        pix_eol;
    logic        frame_done;
    logic        sync_error;

    modport slave (
        input  queue_data, queue_empty, pix_ready,
        output queue_rd_en, pix_data, pix_valid, pix_x, pix_y,
        output pix_sof, pix_eol, frame_done, sync_error
    );

    modport master (
        output queue_data, queue_empty, pix_ready,
        input  queue_rd_en, pix_data, pix_valid, pix_x, pix_y,
        input  pix_sof, pix_eol, frame_done, sync_error
    );
endinterface

// File: rtl/lcd_frame_sink.sv
// Pops tagged words from the LCD output FIFO, parses frame/row markers and emits pixels with x/y.
// Optional LCD_SINK_STATS_EN adds saturating frame_count / error_count outputs.
//
// state      | meaning
// WAIT_FRAME | discard words until a frame-start marker
// WAIT_ROW   | expect a row-start marker
// PIXELS     | forward FRAME_WIDTH pixels of the current row
// WAIT_END   | expect the frame-end marker after the last row
module lcd_frame_sink #(
    parameter int FRAME_WIDTH  = 480,
    parameter int FRAME_HEIGHT = 272
) (
    input  logic                clk,
    input  logic                reset,
`ifdef LCD_SINK_STATS_EN
    output logic [15:0]         frame_count,
    output logic [15:0]         error_count,
`endif
    lcd_frame_sink_if.slave     bus
);

    localparam logic [16:0] MK_SOF = 17'h10000;
    localparam logic [16:0] MK_SOL = 17'h10001;
    localparam logic [16:0] MK_EOF = 17'h1FFFF;
    localparam logic [15:0] COL_LAST = 16'(FRAME_WIDTH - 1);
    localparam logic [15:0] ROW_LAST = 16'(FRAME_HEIGHT - 1);

    typedef enum logic [1:0] {WAIT_FRAME, WAIT_ROW, PIXELS, WAIT_END} state_t;

    state_t      state_q;
    logic [15:0] col_q, row_q;
    logic [15:0] pix_data_q, pix_x_q, pix_y_q;
    logic        pix_valid_q, pix_sof_q, pix_eol_q;
    logic        frame_done_q, sync_error_q;

    logic [16:0] skid_q [2];
    logic [16:0] skid_d [2];
    logic [1:0]  cnt_q, cnt_d;
    logic        inflight_q;

    logic [1:0]  occupancy;
    logic        rd_en;
    logic        head_valid;
    logic [16:0] head;
    logic        slot_free;
    logic        consume;
    logic        push;

    // Pops are only issued while the skid plus the word in flight leave room for the returning data.
    assign occupancy  = cnt_q + {1'b0, inflight_q};
    assign rd_en      = !reset && !bus.queue_empty && (occupancy < 2'd2);
    assign head_valid = (cnt_q != 2'd0) || inflight_q;
    assign head       = (cnt_q != 2'd0) ? skid_q[0] : bus.queue_data;
    assign slot_free  = !pix_valid_q || bus.pix_ready;
    assign consume    = head_valid && ((state_q != PIXELS) || head[16] || slot_free);
    assign push       = inflight_q && !((cnt_q == 2'd0) && consume);

    always_comb begin
        skid_d = skid_q;
        cnt_d  = cnt_q;
        if (consume && (cnt_q != 2'd0)) begin
            skid_d[0] = skid_q[1];
            cnt_d     = cnt_q - 2'd1;
        end
        if (push) begin
            skid_d[cnt_d[0]] = bus.queue_data;
            cnt_d            = cnt_d + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            skid_q[0]  <= '0;
            skid_q[1]  <= '0;
            cnt_q      <= '0;
            inflight_q <= 1'b0;
        end else begin
            skid_q     <= skid_d;
            cnt_q      <= cnt_d;
            inflight_q <= rd_en;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= WAIT_FRAME;
            col_q        <= '0;
            row_q        <= '0;
            pix_data_q   <= '0;
            pix_x_q      <= '0;
            pix_y_q      <= '0;
            pix_valid_q  <= 1'b0;
            pix_sof_q    <= 1'b0;
            pix_eol_q    <= 1'b0;
            frame_done_q <= 1'b0;
            sync_error_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            sync_error_q <= 1'b0;
            if (pix_valid_q && bus.pix_ready) begin
                pix_valid_q <= 1'b0;
            end
            if (consume) begin
                case (state_q)
                    WAIT_FRAME: begin
                        if (head == MK_SOF) begin
                            row_q   <= '0;
                            state_q <= WAIT_ROW;
                        end
                    end
                    WAIT_ROW: begin
                        if (head == MK_SOL) begin
                            col_q   <= '0;
                            state_q <= PIXELS;
                        end else begin
                            sync_error_q <= 1'b1;
                            state_q      <= WAIT_FRAME;
                        end
                    end
                    PIXELS: begin
                        if (!head[16]) begin
                            pix_data_q  <= head[15:0];
                            pix_x_q     <= col_q;
                            pix_y_q     <= row_q;
                            pix_sof_q   <= (col_q == 16'd0) && (row_q == 16'd0);
                            pix_eol_q   <= (col_q == COL_LAST);
                            pix_valid_q <= 1'b1;
                            if (col_q == COL_LAST) begin
                                if (row_q == ROW_LAST) begin
                                    state_q <= WAIT_END;
                                end else begin
                                    row_q   <= row_q + 16'd1;
                                    state_q <= WAIT_ROW;
                                end
                            end else begin
                                col_q <= col_q + 16'd1;
                            end
                        end else begin
                            // A frame start mid-row is taken as the start of a fresh frame.
                            sync_error_q <= 1'b1;
                            if (head == MK_SOF) begin
                                row_q   <= '0;
                                state_q <= WAIT_ROW;
                            end else begin
                                state_q <= WAIT_FRAME;
                            end
                        end
                    end
                    WAIT_END: begin
                        if (head == MK_EOF) begin
                            frame_done_q <= 1'b1;
                        end else begin
                            sync_error_q <= 1'b1;
                        end
                        state_q <= WAIT_FRAME;
                    end
                    default: state_q <= WAIT_FRAME;
                endcase
            end
        end
    end

    assign bus.queue_rd_en = rd_en;
    assign bus.pix_data    = pix_data_q;
    assign bus.pix_valid   = pix_valid_q;
    assign bus.pix_x       = pix_x_q;
    assign bus.pix_y       = pix_y_q;
    assign bus.pix_sof     = pix_sof_q;
    assign bus.pix_eol     = pix_eol_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.sync_error  = sync_error_q;

`ifdef LCD_SINK_STATS_EN
    logic [15:0] frame_count_q, error_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_count_q <= '0;
            error_count_q <= '0;
        end else begin
            if (frame_done_q && (frame_count_q != 16'hFFFF)) begin
                frame_count_q <= frame_count_q + 16'd1;
            end
            if (sync_error_q && (error_count_q != 16'hFFFF)) begin
                error_count_q <= error_count_q + 16'd1;
            end
        end
    end

    assign frame_count = frame_count_q;
    assign error_count = error_count_q;
`endif

endmodule

// File: tb/tb_lcd_frame_sink.sv
// Randomised stream bench for lcd_frame_sink: expected pixels and event counts are built alongside the stimulus.
module tb_lcd_frame_sink;

    localparam int W = 23;
    localparam int H = 17;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    lcd_frame_sink_if bus ();

`ifdef LCD_SINK_STATS_EN
    logic [15:0] frame_count, error_count;
    lcd_frame_sink #(.FRAME_WIDTH(W), .FRAME_HEIGHT(H)) dut (
        .clk(clk), .reset(reset),
        .frame_count(frame_count), .error_count(error_count),
        .bus(bus)
    );
`else
    lcd_frame_sink #(.FRAME_WIDTH(W), .FRAME_HEIGHT(H)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
`endif

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [16:0] fifo [$];
    logic [49:0] expq [$];
    int ready_pct  = 100;
    int bubble_pct = 0;
    bit rst_req    = 1'b1;

    int n_acc = 0, n_eol = 0, n_sof = 0, n_done = 0, n_err = 0;
    int last_y = 0;

    logic        p_valid, p_ready, p_rd, p_empty;
    logic [49:0] p_rec;

    function automatic logic [49:0] cur_rec();
        return {bus.pix_data, bus.pix_x, bus.pix_y, bus.pix_sof, bus.pix_eol};
    endfunction

    initial begin
        bus.queue_data  = '0;
        bus.queue_empty = 1'b1;
        bus.pix_ready   = 1'b0;
        p_valid = 0; p_ready = 0; p_rd = 0; p_empty = 1; p_rec = '0;
        forever begin
            @(negedge clk);
            if (rst_req) begin
                reset = 1'b1;
                fifo.delete();
                expq.delete();
                bus.queue_empty = 1'b1;
                bus.pix_ready   = 1'b0;
                @(negedge clk);
                check("rst_ctl", 64'({bus.queue_rd_en, bus.pix_valid, bus.pix_sof, bus.pix_eol,
                                      bus.frame_done, bus.sync_error}), 64'd0);
                check("rst_pix", 64'({bus.pix_data, bus.pix_x, bus.pix_y}), 64'd0);
                reset   = 1'b0;
                rst_req = 1'b0;
                p_valid = 0; p_ready = 0; p_rd = 0; p_empty = 1;
                continue;
            end
            if (p_rd && !p_empty) bus.queue_data = fifo.pop_front();
            if (p_valid && p_ready) begin
                check("exp_avail", 64'(expq.size() != 0), 64'd1);
                if (expq.size() != 0) check("pixel", 64'(p_rec), 64'(expq.pop_front()));
                n_acc++;
                n_eol += int'(p_rec[0]);
                n_sof += int'(p_rec[1]);
                last_y = int'(p_rec[17:2]);
            end
            if (p_valid && !p_ready)
                check("stall_hold", 64'({bus.pix_valid, cur_rec()}), 64'({1'b1, p_rec}));
            n_done += int'(bus.frame_done);
            n_err  += int'(bus.sync_error);
            bus.queue_empty = (fifo.size() == 0) || ($urandom_range(99) < bubble_pct);
            bus.pix_ready   = ($urandom_range(99) < ready_pct);
            #1;
            p_valid = bus.pix_valid;
            p_ready = bus.pix_ready;
            p_rd    = bus.queue_rd_en;
            p_empty = bus.queue_empty;
            p_rec   = cur_rec();
        end
    end

    task automatic push_pixel(input int x, input int y);
        logic [15:0] d;
        d = 16'($urandom);
        fifo.push_back({1'b0, d});
        expq.push_back({d, 16'(x), 16'(y), (x == 0) && (y == 0), x == W - 1});
    endtask

    task automatic add_frame(input bit with_eof);
        fifo.push_back(17'h10000);
        for (int r = 0; r < H; r++) begin
            fifo.push_back(17'h10001);
            for (int c = 0; c < W; c++) push_pixel(c, r);
        end
        if (with_eof) fifo.push_back(17'h1FFFF);
    endtask

    int s_acc, s_eol, s_sof, s_done, s_err;

    task automatic snap();
        s_acc = n_acc; s_eol = n_eol; s_sof = n_sof; s_done = n_done; s_err = n_err;
    endtask

    task automatic drain_and_check(input string tag, input int e_acc, input int e_eol,
                                   input int e_sof, input int e_done, input int e_err);
        bit drained;
        drained = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk); #2;
            if (fifo.size() == 0 && expq.size() == 0) begin
                drained = 1'b1;
                break;
            end
        end
        repeat (10) @(negedge clk);
        #2;
        check({tag, "_drain"}, 64'(drained), 64'd1);
        check({tag, "_pixels"}, 64'(n_acc - s_acc), 64'(e_acc));
        check({tag, "_eol"}, 64'(n_eol - s_eol), 64'(e_eol));
        check({tag, "_sof"}, 64'(n_sof - s_sof), 64'(e_sof));
        check({tag, "_done"}, 64'(n_done - s_done), 64'(e_done));
        check({tag, "_err"}, 64'(n_err - s_err), 64'(e_err));
    endtask

    initial begin
        bit hit;
        wait (rst_req == 1'b0);
        repeat (2) @(negedge clk);
        #2;

        // full-rate frame
        snap(); ready_pct = 100; bubble_pct = 0;
        add_frame(1'b1);
        drain_and_check("full", W * H, H, 1, 1, 0);

        // random backpressure and FIFO bubbles
        snap(); ready_pct = 50; bubble_pct = 20;
        add_frame(1'b1);
        drain_and_check("stall", W * H, H, 1, 1, 0);

        // garbage before the first frame start
        snap(); ready_pct = 70; bubble_pct = 10;
        fifo.push_back(17'h01234);
        fifo.push_back(17'h10001);
        add_frame(1'b1);
        drain_and_check("garbage", W * H, H, 1, 1, 0);

        // short row followed by a row marker, then a clean frame
        snap();
        fifo.push_back(17'h10000);
        fifo.push_back(17'h10001);
        for (int c = 0; c < 10; c++) push_pixel(c, 0);
        fifo.push_back(17'h10001);
        add_frame(1'b1);
        drain_and_check("short_row", W * H + 10, H, 2, 1, 1);

        // missing frame end: a pixel arrives where the end marker belongs
        begin
`ifdef LCD_SINK_STATS_EN
            logic [15:0] fc0, ec0;
            fc0 = frame_count;
            ec0 = error_count;
`endif
            snap();
            add_frame(1'b0);
            fifo.push_back(17'h00ABC);
            drain_and_check("no_eof", W * H, H, 1, 0, 1);
`ifdef LCD_SINK_STATS_EN
            check("stat_frames", 64'(frame_count), 64'(fc0));
            check("stat_errors", 64'(error_count), 64'(ec0 + 16'd1));
`endif
        end

        // reset in the middle of row 5, then a complete frame
        ready_pct = 100; bubble_pct = 0; last_y = 0;
        add_frame(1'b1);
        hit = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk); #2;
            if (last_y == 5) begin
                hit = 1'b1;
                break;
            end
        end
        check("reach_row5", 64'(hit), 64'd1);
        rst_req = 1'b1;
        for (int i = 0; i < 20 && rst_req; i++) begin
            @(negedge clk); #2;
        end
        check("rst_served", 64'(rst_req), 64'd0);
        @(negedge clk); #2;
        snap(); ready_pct = 80; bubble_pct = 10;
        add_frame(1'b1);
        drain_and_check("post_rst", W * H, H, 1, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
